// File: rtl/idu_hazard_scoreboard.sv
// Decode-side issue gate: one held instruction, blocked while any operand has an in-flight writer.
// Optional CSR tracking is compiled in when YSYX_23060059_CSR_TRACK_EN is defined.

module idu_hazard_scoreboard_chk #(
  parameter int PW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          gpr_ret,
  input logic [PW-1:0] gpr_cur,
  input logic          csr_ret,
  input logic [PW-1:0] csr_cur,
  input logic          tot_ret,
  input logic [PW-1:0] tot_cur
);
  // A retire against an empty counter means the WBU reported a writer that was never issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(gpr_ret && gpr_cur == PW'(0))) else $error("gpr_pend underflow on retire");
      assert (!(csr_ret && csr_cur == PW'(0))) else $error("csr_pend underflow on retire");
      assert (!(tot_ret && tot_cur == PW'(0))) else $error("total_pend underflow on retire");
    end
  end
endmodule

module idu_hazard_scoreboard #(
  parameter int NREG         = 32,
  parameter int NCSR         = 4,
  parameter int MAX_INFLIGHT = 3,
  localparam int RW = $clog2(NREG),
  localparam int CW = $clog2(NCSR),
  localparam int PW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic          in_rs1_en,
  input  logic          in_rs2_en,
  input  logic [RW-1:0] in_rd,
  input  logic          in_rd_wen,
  input  logic [CW-1:0] in_csr_rs,
  input  logic          in_csr_rs_en,
  input  logic [CW-1:0] in_csr_rd,
  input  logic          in_csr_wen,
  input  logic [63:0]   in_payload,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_payload,
  output logic [RW-1:0] out_rd,
  output logic          out_rd_wen,
  output logic [CW-1:0] out_csr_rd,
  output logic          out_csr_wen,
  input  logic          ret_valid,
  input  logic [RW-1:0] ret_rd,
  input  logic          ret_rd_wen,
  input  logic [CW-1:0] ret_csr_rd,
  input  logic          ret_csr_wen,
  input  logic          flush,
  output logic [31:0]   stall_cnt
);
  logic          hold_valid;
  logic [RW-1:0] hold_rs1, hold_rs2, hold_rd;
  logic          hold_rs1_en, hold_rs2_en, hold_rd_wen;
  logic [CW-1:0] hold_csr_rd;
  logic          hold_csr_wen;
  logic [63:0]   hold_payload;
  logic [PW-1:0] gpr_pend [NREG];
  logic [PW-1:0] total_pend;
  logic [NREG-1:0] gpr_inc, gpr_dec;
  logic hazard, gpr_haz, csr_haz, full, issue, capture;
  logic gpr_wr_issue, gpr_wr_ret, csr_wr_issue, csr_wr_ret, tot_inc, tot_dec;
  logic [PW-1:0] csr_cur;

  // Same-edge increment and decrement cancel; a decrement at zero is dropped.
  function automatic logic [PW-1:0] step_pend(input logic [PW-1:0] cur, input logic inc, input logic dec);
    logic [PW-1:0] nxt;
    if (inc && !dec) nxt = cur + PW'(1);
    else if (dec && !inc && cur != PW'(0)) nxt = cur - PW'(1);
    else nxt = cur;
    return nxt;
  endfunction

  assign gpr_haz = (hold_rs1_en && hold_rs1 != RW'(0) && gpr_pend[hold_rs1] != PW'(0)) ||
                   (hold_rs2_en && hold_rs2 != RW'(0) && gpr_pend[hold_rs2] != PW'(0)) ||
                   (hold_rd_wen && hold_rd  != RW'(0) && gpr_pend[hold_rd]  != PW'(0));
  assign full      = (total_pend == PW'(MAX_INFLIGHT));
  assign hazard    = gpr_haz || csr_haz || full;
  assign out_valid = hold_valid && !hazard;
  assign in_ready  = !hold_valid || (out_valid && out_ready);
  assign issue     = out_valid && out_ready && !flush;
  assign capture   = in_valid && in_ready && !flush;

  assign gpr_wr_issue = issue && hold_rd_wen && (hold_rd != RW'(0));
  assign gpr_wr_ret   = ret_valid && ret_rd_wen && (ret_rd != RW'(0));
  assign tot_inc      = gpr_wr_issue || csr_wr_issue;
  assign tot_dec      = gpr_wr_ret || csr_wr_ret;

`ifdef YSYX_23060059_CSR_TRACK_EN
  logic [CW-1:0]   hold_csr_rs;
  logic            hold_csr_rs_en;
  logic [PW-1:0]   csr_pend [NCSR];
  logic [NCSR-1:0] csr_inc, csr_dec;

  assign csr_haz = (hold_csr_rs_en && csr_pend[hold_csr_rs] != PW'(0)) ||
                   (hold_csr_wen   && csr_pend[hold_csr_rd] != PW'(0));
  assign csr_wr_issue = issue && hold_csr_wen;
  assign csr_wr_ret   = ret_valid && ret_csr_wen;
  assign csr_cur      = csr_pend[ret_csr_rd];

  // Per-CSR increment/decrement strobes.
  always_comb begin
    csr_inc = {NCSR{1'b0}};
    csr_dec = {NCSR{1'b0}};
    for (int i = 0; i < NCSR; i++) begin
      csr_inc[i] = csr_wr_issue && (hold_csr_rd == CW'(i));
      csr_dec[i] = csr_wr_ret && (ret_csr_rd == CW'(i));
    end
  end

  // CSR pending counters and captured CSR source.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCSR; i++) csr_pend[i] <= PW'(0);
      hold_csr_rs    <= CW'(0);
      hold_csr_rs_en <= 1'b0;
    end else begin
      for (int i = 0; i < NCSR; i++) csr_pend[i] <= step_pend(csr_pend[i], csr_inc[i], csr_dec[i]);
      if (capture) begin
        hold_csr_rs    <= in_csr_rs;
        hold_csr_rs_en <= in_csr_rs_en;
      end
    end
  end
`else
  logic csr_unused;
  assign csr_unused   = ^{in_csr_rs, in_csr_rs_en, ret_csr_rd, ret_csr_wen};
  assign csr_haz      = 1'b0;
  assign csr_wr_issue = 1'b0;
  assign csr_wr_ret   = 1'b0;
  assign csr_cur      = PW'(0);
`endif

  // Per-GPR increment/decrement strobes; x0 never matches because of the rd!=0 qualifiers.
  always_comb begin
    gpr_inc = {NREG{1'b0}};
    gpr_dec = {NREG{1'b0}};
    for (int i = 0; i < NREG; i++) begin
      gpr_inc[i] = gpr_wr_issue && (hold_rd == RW'(i));
      gpr_dec[i] = gpr_wr_ret && (ret_rd == RW'(i));
    end
  end

  // GPR and total pending counters; flush leaves them alone since writers still retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr_pend[i] <= PW'(0);
      total_pend <= PW'(0);
    end else begin
      for (int i = 0; i < NREG; i++) gpr_pend[i] <= step_pend(gpr_pend[i], gpr_inc[i], gpr_dec[i]);
      total_pend <= step_pend(total_pend, tot_inc, tot_dec);
    end
  end

  // Holding register; a capture on the issue edge keeps it full for back-to-back flow.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid   <= 1'b0;
      hold_rs1     <= RW'(0);
      hold_rs2     <= RW'(0);
      hold_rs1_en  <= 1'b0;
      hold_rs2_en  <= 1'b0;
      hold_rd      <= RW'(0);
      hold_rd_wen  <= 1'b0;
      hold_csr_rd  <= CW'(0);
      hold_csr_wen <= 1'b0;
      hold_payload <= 64'd0;
    end else if (flush) begin
      hold_valid <= 1'b0;
    end else if (capture) begin
      hold_valid   <= 1'b1;
      hold_rs1     <= in_rs1;
      hold_rs2     <= in_rs2;
      hold_rs1_en  <= in_rs1_en;
      hold_rs2_en  <= in_rs2_en;
      hold_rd      <= in_rd;
      hold_rd_wen  <= in_rd_wen;
      hold_csr_rd  <= in_csr_rd;
      hold_csr_wen <= in_csr_wen;
      hold_payload <= in_payload;
    end else if (issue) begin
      hold_valid <= 1'b0;
    end else begin
      hold_valid <= hold_valid;
    end
  end

  // Saturating count of cycles the held instruction is blocked.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (hold_valid && hazard && !flush && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign out_payload = hold_payload;
  assign out_rd      = hold_rd;
  assign out_rd_wen  = hold_rd_wen;
  assign out_csr_rd  = hold_csr_rd;
  assign out_csr_wen = hold_csr_wen;

  idu_hazard_scoreboard_chk #(.PW(PW)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .gpr_ret (gpr_wr_ret),
    .gpr_cur (gpr_pend[ret_rd]),
    .csr_ret (csr_wr_ret),
    .csr_cur (csr_cur),
    .tot_ret (tot_dec),
    .tot_cur (total_pend)
  );
endmodule

// File: tb/tb_idu_hazard_scoreboard.sv
// Bench for idu_hazard_scoreboard: directed scenarios then random traffic against a counting model.
module tb_idu_hazard_scoreboard;
  localparam int NREG = 32;
  localparam int NCSR = 4;
  localparam int MAXF = 3;
`ifdef YSYX_23060059_CSR_TRACK_EN
  localparam bit CSR_EN = 1'b1;
`else
  localparam bit CSR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, in_rs1_en, in_rs2_en, in_rd_wen, in_csr_rs_en, in_csr_wen;
  logic [4:0] in_rs1, in_rs2, in_rd, out_rd, ret_rd;
  logic [1:0] in_csr_rs, in_csr_rd, out_csr_rd, ret_csr_rd;
  logic [63:0] in_payload, out_payload;
  logic out_valid, out_ready, out_rd_wen, out_csr_wen;
  logic ret_valid, ret_rd_wen, ret_csr_wen, flush;
  logic [31:0] stall_cnt;

  idu_hazard_scoreboard #(.NREG(NREG), .NCSR(NCSR), .MAX_INFLIGHT(MAXF)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_csr_rs(in_csr_rs), .in_csr_rs_en(in_csr_rs_en),
    .in_csr_rd(in_csr_rd), .in_csr_wen(in_csr_wen), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_csr_rd(out_csr_rd), .out_csr_wen(out_csr_wen),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_rd_wen(ret_rd_wen),
    .ret_csr_rd(ret_csr_rd), .ret_csr_wen(ret_csr_wen), .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit g; logic [4:0] rd; bit c; logic [1:0] crd; } wr_t;

  int total = 0;
  int bad = 0;

  // Reference model: held instruction, per-register in-flight counts, FIFO of writers awaiting retire.
  bit          m_hold;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  bit          m_rs1_en, m_rs2_en, m_rd_wen, m_crs_en, m_cwen;
  logic [1:0]  m_crs, m_crd;
  logic [63:0] m_pay;
  int          gp[NREG];
  int          cp[NCSR];
  int          tot;
  logic [31:0] m_stall;
  wr_t         q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hazard();
    bit h;
    h = (m_rs1_en && m_rs1 != 5'd0 && gp[m_rs1] > 0) ||
        (m_rs2_en && m_rs2 != 5'd0 && gp[m_rs2] > 0) ||
        (m_rd_wen && m_rd  != 5'd0 && gp[m_rd]  > 0) || (tot == MAXF);
    if (CSR_EN) h = h || (m_crs_en && cp[m_crs] > 0) || (m_cwen && cp[m_crd] > 0);
    return h;
  endfunction

  task automatic drive(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                       input int rd, input bit w, input bit ordy, input bit fl);
    in_valid = v; in_rs1 = 5'(rs1); in_rs1_en = e1; in_rs2 = 5'(rs2); in_rs2_en = e2;
    in_rd = 5'(rd); in_rd_wen = w; in_payload = {$urandom(), $urandom()};
    in_csr_rs = 2'd0; in_csr_rs_en = 1'b0; in_csr_rd = 2'd0; in_csr_wen = 1'b0;
    out_ready = ordy; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  // One clock: optionally retire the oldest writer, compare outputs, advance the model.
  task automatic cycle(input bit do_ret);
    bit hz, ov, ir, iss, cap;
    wr_t w;
    ret_valid = 1'b0; ret_rd = 5'd0; ret_rd_wen = 1'b0; ret_csr_rd = 2'd0; ret_csr_wen = 1'b0;
    if (do_ret && q.size() > 0) begin
      ret_valid = 1'b1; ret_rd = q[0].rd; ret_rd_wen = q[0].g;
      ret_csr_rd = q[0].crd; ret_csr_wen = q[0].c;
    end
    #1;
    hz = m_hazard();
    ov = m_hold && !hz;
    ir = !m_hold || (ov && out_ready);
    check("out_valid", out_valid, ov);
    check("in_ready", in_ready, ir);
    check("stall_cnt", stall_cnt, m_stall);
    check("out_payload", out_payload, m_pay);
    check("out_rd", out_rd, m_rd);
    check("out_rd_wen", out_rd_wen, m_rd_wen);
    check("out_csr_rd", out_csr_rd, m_crd);
    check("out_csr_wen", out_csr_wen, m_cwen);
    check("total_pend", dut.total_pend, tot);
    for (int i = 0; i < NREG; i++) check($sformatf("gpr_pend[%0d]", i), dut.gpr_pend[i], gp[i]);
    iss = ov && out_ready && !flush;
    cap = in_valid && ir && !flush;
    if (ret_valid) begin
      w = q.pop_front();
      if (w.g) gp[w.rd]--;
      if (w.c) cp[w.crd]--;
      if (w.g || w.c) tot--;
    end
    if (iss) begin
      w.g = m_rd_wen && m_rd != 5'd0; w.rd = m_rd; w.c = CSR_EN && m_cwen; w.crd = m_crd;
      if (w.g) gp[w.rd]++;
      if (w.c) cp[w.crd]++;
      if (w.g || w.c) begin tot++; q.push_back(w); end
    end
    if (m_hold && hz && !flush && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (flush) m_hold = 1'b0;
    else if (cap) begin
      m_hold = 1'b1; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rs1_en = in_rs1_en; m_rs2_en = in_rs2_en;
      m_rd = in_rd; m_rd_wen = in_rd_wen; m_crs = in_csr_rs; m_crs_en = in_csr_rs_en;
      m_crd = in_csr_rd; m_cwen = in_csr_wen; m_pay = in_payload;
    end else if (iss) m_hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_hold = 1'b0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0; m_rs1_en = 1'b0; m_rs2_en = 1'b0;
    m_rd_wen = 1'b0; m_crs = 2'd0; m_crs_en = 1'b0; m_crd = 2'd0; m_cwen = 1'b0; m_pay = 64'd0;
    for (int i = 0; i < NREG; i++) gp[i] = 0;
    for (int i = 0; i < NCSR; i++) cp[i] = 0;
    tot = 0; m_stall = 32'd0;
    ret_valid = 1'b0; ret_rd = 5'd0; ret_rd_wen = 1'b0; ret_csr_rd = 2'd0; ret_csr_wen = 1'b0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_payload", out_payload, 64'd0);
    check("rst_out_rd", out_rd, 5'd0);
    check("rst_stall", stall_cnt, 32'd0);
    check("rst_total", dut.total_pend, 2'd0);
    rst = 1'b0;

    // Independent stream rd=1,2,3, each retired one cycle after issue.
    drive(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    check("t1_ov_a", out_valid, 1'b1);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    check("t1_ov_b", out_valid, 1'b1);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b1, 1'b0); cycle(1'b1);
    check("t1_ov_c", out_valid, 1'b1);
    idle(); cycle(1'b1);
    idle(); cycle(1'b1);
    check("t1_stall", stall_cnt, 32'd0);
    check("t1_total", dut.total_pend, 2'd0);

    // RAW on x5: blocked four cycles, issues the cycle after the retire.
    drive(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    drive(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0); cycle(1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t2_blocked", out_valid, 1'b0);
      idle(); cycle(1'b0);
    end
    check("t2_blocked_ret", out_valid, 1'b0);
    idle(); cycle(1'b1);
    check("t2_released", out_valid, 1'b1);
    check("t2_stall", stall_cnt, 32'd4);
    idle(); cycle(1'b0);

    // x0 is never pending.
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    drive(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0); cycle(1'b0);
    check("t3_ov", out_valid, 1'b1);
    check("t3_gp0", dut.gpr_pend[0], 2'd0);
    idle(); cycle(1'b0);
    check("t3_stall", stall_cnt, 32'd4);

    // Depth: three writers in flight block a fourth until one retires.
    for (int r = 1; r <= 4; r++) begin
      drive(1'b1, 0, 1'b0, 0, 1'b0, r, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    end
    check("t4_full", dut.total_pend, 2'd3);
    check("t4_blk_a", out_valid, 1'b0);
    idle(); cycle(1'b0);
    check("t4_blk_b", out_valid, 1'b0);
    idle(); cycle(1'b1);
    check("t4_go", out_valid, 1'b1);
    check("t4_stall", stall_cnt, 32'd6);
    for (int k = 0; k < 3; k++) begin idle(); cycle(1'b1); end
    check("t4_drained", dut.total_pend, 2'd0);

    // Issue of rd=8 on the same edge as retire of rd=7 leaves the total unchanged.
    drive(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    idle(); cycle(1'b0);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    idle(); cycle(1'b1);
    check("t5_total", dut.total_pend, 2'd1);
    check("t5_gp7", dut.gpr_pend[7], 2'd0);
    check("t5_gp8", dut.gpr_pend[8], 2'd1);
    idle(); cycle(1'b1);

    // Flush while blocked on RAW: hold dropped, capture suppressed, counters kept.
    drive(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0); cycle(1'b0);
    drive(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0); cycle(1'b0);
    idle(); cycle(1'b0);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1, 1'b1); cycle(1'b0);
    check("t6_ov", out_valid, 1'b0);
    check("t6_ready", in_ready, 1'b1);
    check("t6_gp5", dut.gpr_pend[5], 2'd1);
    check("t6_stall", stall_cnt, 32'd7);
    idle(); cycle(1'b1);
    check("t6_total", dut.total_pend, 2'd0);

`ifdef YSYX_23060059_CSR_TRACK_EN
    // csrrw to csr 2 in flight blocks a csrrs reading csr 2.
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    in_csr_rd = 2'd2; in_csr_wen = 1'b1; cycle(1'b0);
    drive(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    in_csr_rs = 2'd2; in_csr_rs_en = 1'b1; cycle(1'b0);
    check("t7_blk_a", out_valid, 1'b0);
    idle(); cycle(1'b0);
    check("t7_blk_b", out_valid, 1'b0);
    idle(); cycle(1'b1);
    check("t7_go", out_valid, 1'b1);
    idle(); cycle(1'b0);
`endif

    // Random traffic with narrow register ranges to provoke frequent hazards.
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
            $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      in_csr_rs = 2'($urandom_range(0, 3)); in_csr_rs_en = 1'($urandom_range(0, 1));
      in_csr_rd = 2'($urandom_range(0, 3)); in_csr_wen = 1'($urandom_range(0, 1));
      cycle($urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
